// File: rtl/descriptor_arbiter_if.sv
// Descriptor arbiter bus: per-port upstream wr/ack/descriptor, shared downstream wr/ack, status.
interface descriptor_arbiter_if #(
  parameter int PORT_NUM = 4,
  parameter int PW       = 2,
  parameter int DES_W    = 46
);
  logic [PORT_NUM-1:0]       iv_descriptor_wr;
  logic [PORT_NUM*DES_W-1:0] iv_descriptor;
  logic [PORT_NUM-1:0]       ov_descriptor_ack;
  logic                      o_descriptor_wr;
  logic [DES_W-1:0]          ov_descriptor;
  logic [PW-1:0]             ov_descriptor_src;
  logic                      i_descriptor_ack;
  logic                      o_timeout_err;
  logic [15:0]               ov_drop_cnt;
  logic [1:0]                ov_arb_state;

  // master: the upstream senders plus downstream consumer; slave: the arbiter
  modport master (
    output iv_descriptor_wr, iv_descriptor, i_descriptor_ack,
    input  ov_descriptor_ack, o_descriptor_wr, ov_descriptor, ov_descriptor_src,
           o_timeout_err, ov_drop_cnt, ov_arb_state
  );
  modport slave (
    input  iv_descriptor_wr, iv_descriptor, i_descriptor_ack,
    output ov_descriptor_ack, o_descriptor_wr, ov_descriptor, ov_descriptor_src,
           o_timeout_err, ov_drop_cnt, ov_arb_state
  );
endinterface

// File: rtl/descriptor_arbiter.sv
// Round-robin arbiter forwarding one held upstream descriptor at a time to the shared
// forwarding stage, with a watchdog that drops a descriptor the downstream never acks.
module descriptor_arbiter #(
  parameter int PORT_NUM    = 4,
  parameter int PW          = 2,
  parameter int DES_W       = 46,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk_sys,
  input  logic reset_n,
  descriptor_arbiter_if.slave bus
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE_S     = 2'b00,
    WAIT_ACK_S = 2'b01,
    GAP_S      = 2'b10,
    BAD_S      = 2'b11
  } state_t;

  state_t          state;
  logic [PW-1:0]   last_grant;
  logic [TW-1:0]   timer;
  logic [DES_W-1:0] desc_arr [PORT_NUM];
  logic            found;
  logic [PW-1:0]   grant;
  logic [PW:0]     sum;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_unpack
    assign desc_arr[i] = bus.iv_descriptor[DES_W*i +: DES_W];
  end

  // Walk from farthest to nearest so the nearest requester after last_grant wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    sum   = '0;
    for (int k = PORT_NUM; k >= 1; k--) begin
      sum = {1'b0, last_grant} + (PW+1)'(k);
      if (sum >= (PW+1)'(PORT_NUM)) sum = sum - (PW+1)'(PORT_NUM);
      if (bus.iv_descriptor_wr[sum[PW-1:0]]) begin
        found = 1'b1;
        grant = sum[PW-1:0];
      end
    end
  end

  assign bus.ov_arb_state = state;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state                 <= IDLE_S;
      last_grant            <= PW'(PORT_NUM - 1);
      timer                 <= '0;
      bus.ov_descriptor_ack <= '0;
      bus.o_descriptor_wr   <= 1'b0;
      bus.ov_descriptor     <= '0;
      bus.ov_descriptor_src <= '0;
      bus.o_timeout_err     <= 1'b0;
      bus.ov_drop_cnt       <= '0;
    end else begin
      bus.ov_descriptor_ack <= '0;
      bus.o_timeout_err     <= 1'b0;
      case (state)
        IDLE_S: begin
          if (found) begin
            bus.ov_descriptor     <= desc_arr[grant];
            bus.ov_descriptor_src <= grant;
            bus.o_descriptor_wr   <= 1'b1;
            bus.ov_descriptor_ack <= {{(PORT_NUM-1){1'b0}}, 1'b1} << grant;
            last_grant            <= grant;
            timer                 <= '0;
            state                 <= WAIT_ACK_S;
          end
        end
        WAIT_ACK_S: begin
          if (bus.i_descriptor_ack) begin
            bus.o_descriptor_wr   <= 1'b0;
            bus.ov_descriptor     <= '0;
            bus.ov_descriptor_src <= '0;
            state                 <= GAP_S;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            bus.o_descriptor_wr   <= 1'b0;
            bus.ov_descriptor     <= '0;
            bus.ov_descriptor_src <= '0;
            bus.o_timeout_err     <= 1'b1;
            if (bus.ov_drop_cnt != 16'hFFFF) bus.ov_drop_cnt <= bus.ov_drop_cnt + 16'd1;
            state                 <= GAP_S;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // One dead cycle lets the acked sender drop wr before the next sample.
        GAP_S: state <= IDLE_S;
        default: begin
          bus.o_descriptor_wr   <= 1'b0;
          bus.ov_descriptor     <= '0;
          bus.ov_descriptor_src <= '0;
          state                 <= IDLE_S;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_descriptor_arbiter.sv
// Randomized scoreboard bench: a transaction-level model predicts each grant and its outcome.
module tb_descriptor_arbiter;
  localparam int P = 4, PW = 2, DW = 46, TO = 255, NEVER = 1000;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  descriptor_arbiter_if #(.PORT_NUM(P), .PW(PW), .DES_W(DW)) bus ();
  descriptor_arbiter #(.PORT_NUM(P), .PW(PW), .DES_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk_sys(clk), .reset_n(rst_n), .bus(bus));

  int vectors = 0, miscompares = 0;

  typedef struct {
    int port; logic [DW-1:0] desc; longint edge_no; int n; bit to; int drop;
  } exp_t;
  exp_t exp_q[$];
  int   dq[$];

  bit model_en = 1'b0, chk_en = 1'b0;
  longint edge_no = 0, free_edge = 0;
  int last = P - 1, n_tx = 0, exp_drop = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a grant happens on the first edge the arbiter is free and someone requests;
  // the transaction then lasts n cycles, plus a one-cycle gap before the next sample.
  always @(posedge clk) if (model_en) begin
    exp_t t;
    int p, d;
    edge_no++;
    if (edge_no >= free_edge) begin
      for (int k = 1; k <= P; k++) begin
        p = (last + k) % P;
        if (bus.iv_descriptor_wr[p]) begin
          n_tx++;
          if (n_tx == 3) d = NEVER;
          else if (n_tx == 6) d = TO - 1;
          else if ($urandom_range(0, 39) == 0) d = NEVER;
          else d = $urandom_range(0, 3);
          t.port    = p;
          t.desc    = bus.iv_descriptor[DW*p +: DW];
          t.edge_no = edge_no;
          t.n       = (d < TO) ? d + 1 : TO;
          t.to      = (d >= TO);
          exp_drop  += int'(t.to);
          t.drop    = exp_drop;
          exp_q.push_back(t);
          dq.push_back(d);
          last      = p;
          free_edge = edge_no + t.n + 2;
          break;
        end
      end
    end
  end

  // Downstream consumer: acks after the delay chosen by the model; stray acks while idle.
  int rcnt = 0, rd = NEVER;
  logic rprev = 1'b0;
  always @(negedge clk) begin
    bus.i_descriptor_ack = 1'b0;
    if (bus.o_descriptor_wr && !rprev) begin
      rcnt = 1;
      rd = (dq.size() > 0) ? dq.pop_front() : NEVER;
    end else if (bus.o_descriptor_wr) rcnt++;
    if (bus.o_descriptor_wr && rcnt == rd + 1) bus.i_descriptor_ack = 1'b1;
    else if (!bus.o_descriptor_wr && $urandom_range(0, 7) == 0) bus.i_descriptor_ack = 1'b1;
    rprev = bus.o_descriptor_wr;
  end

  // Monitor: pops a prediction on each new downstream descriptor and follows it to the end.
  exp_t cur;
  int   mcnt = 0;
  logic mprev = 1'b0;
  always @(negedge clk) if (chk_en) begin
    if (bus.o_descriptor_wr && !mprev) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_grant: src %0d, no grant predicted", bus.ov_descriptor_src);
      end else begin
        cur = exp_q.pop_front();
        chk("grant_edge", 64'(edge_no), 64'(cur.edge_no));
        chk("grant_src", 64'(bus.ov_descriptor_src), 64'(cur.port));
        chk("grant_desc", 64'(bus.ov_descriptor), 64'(cur.desc));
        chk("grant_ack", 64'(bus.ov_descriptor_ack), 64'(1) << cur.port);
        chk("state_wait", 64'(bus.ov_arb_state), 64'd1);
      end
      mcnt = 1;
    end else if (bus.o_descriptor_wr) begin
      mcnt++;
      chk("ack_width", 64'(bus.ov_descriptor_ack), 64'd0);
      chk("hold_desc", 64'(bus.ov_descriptor), 64'(cur.desc));
      chk("hold_src", 64'(bus.ov_descriptor_src), 64'(cur.port));
      chk("err_idle", 64'(bus.o_timeout_err), 64'd0);
    end else if (mprev) begin
      chk("wr_cycles", 64'(mcnt), 64'(cur.n));
      chk("timeout_err", 64'(bus.o_timeout_err), 64'(cur.to));
      chk("drop_cnt", 64'(bus.ov_drop_cnt), 64'(cur.drop));
      chk("state_gap", 64'(bus.ov_arb_state), 64'd2);
      chk("desc_clear", 64'(bus.ov_descriptor), 64'd0);
    end else begin
      chk("ack_quiet", 64'(bus.ov_descriptor_ack), 64'd0);
      chk("err_quiet", 64'(bus.o_timeout_err), 64'd0);
    end
    mprev = bus.o_descriptor_wr;
  end

  // Senders hold wr until their ack pulse; new requests raised at random.
  task automatic senders(bit en);
    for (int p = 0; p < P; p++) begin
      if (bus.ov_descriptor_ack[p]) bus.iv_descriptor_wr[p] = 1'b0;
      else if (en && !bus.iv_descriptor_wr[p] && $urandom_range(0, 3) == 0) begin
        bus.iv_descriptor[DW*p +: DW] = DW'({$urandom(), $urandom()});
        bus.iv_descriptor_wr[p] = 1'b1;
      end
    end
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_wr"}, 64'(bus.o_descriptor_wr), 64'd0);
    chk({tag, "_desc"}, 64'(bus.ov_descriptor), 64'd0);
    chk({tag, "_src"}, 64'(bus.ov_descriptor_src), 64'd0);
    chk({tag, "_ack"}, 64'(bus.ov_descriptor_ack), 64'd0);
    chk({tag, "_err"}, 64'(bus.o_timeout_err), 64'd0);
    chk({tag, "_drop"}, 64'(bus.ov_drop_cnt), 64'd0);
    chk({tag, "_state"}, 64'(bus.ov_arb_state), 64'd0);
  endtask

  initial begin
    logic [DW-1:0] d0, d2;
    bit done;
    d0 = 46'h0_0ABC_DEF0_12;
    d2 = 46'h1_2345_6789_AB;
    bus.iv_descriptor_wr = '0;
    bus.iv_descriptor    = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");

    rst_n = 1'b1; model_en = 1'b1; chk_en = 1'b1;
    repeat (1500) begin @(negedge clk); senders(1'b1); end

    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      senders(1'b0);
      done = (bus.iv_descriptor_wr == '0) && (bus.ov_arb_state == 2'd0) &&
             !bus.o_descriptor_wr && (exp_q.size() == 0);
    end
    chk("drain_done", 64'(done), 64'd1);
    model_en = 1'b0; chk_en = 1'b0;

    // Lone port 2 request, then reset while waiting for the downstream ack.
    bus.iv_descriptor[DW*2 +: DW] = d2;
    bus.iv_descriptor_wr = 4'b0100;
    @(negedge clk);
    chk("dir_wr", 64'(bus.o_descriptor_wr), 64'd1);
    chk("dir_src", 64'(bus.ov_descriptor_src), 64'd2);
    chk("dir_desc", 64'(bus.ov_descriptor), 64'(d2));
    chk("dir_ack", 64'(bus.ov_descriptor_ack), 64'b0100);
    @(negedge clk);
    chk("dir_ack_drop", 64'(bus.ov_descriptor_ack), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    bus.iv_descriptor[0 +: DW] = d0;
    bus.iv_descriptor_wr = 4'b1101;
    @(negedge clk);
    chk("post_reset_src", 64'(bus.ov_descriptor_src), 64'd0);
    chk("post_reset_desc", 64'(bus.ov_descriptor), 64'(d0));
    chk("post_reset_ack", 64'(bus.ov_descriptor_ack), 64'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/descriptor_arbiter.md
Name: descriptor_arbiter

Overview:
- Shares one downstream descriptor path (towards lookup/forwarding) among PORT_NUM per-port frame-parser descriptor senders.
- Each upstream sender holds a descriptor with a wr/ack handshake. This block picks one by round-robin, registers it, tags it with the source port, and forwards it.
- It waits for the downstream ack, guarded by a watchdog.
- It sits between the per-port network_input_process instances and the shared forwarding stage.

Parameters:
- PORT_NUM, 4, number of upstream requesters (implementation supports 2..8).
- PW, 2, width of source-port tag (clog2 of PORT_NUM).
- DES_W, 46, descriptor width; bits [8:0] carry the packet buffer id.
- ACK_TIMEOUT, 255, max cycles to wait for downstream ack before dropping.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  synchronous active-low reset, sampled on rising clk_sys.
- iv_descriptor_wr  in  PORT_NUM  per-port request; held high by the sender until acked.
- iv_descriptor  in  PORT_NUM*DES_W  port i at [DES_W*i+DES_W-1 : DES_W*i].
- ov_descriptor_ack  out  PORT_NUM  one-cycle ack pulse to the granted port.
- o_descriptor_wr  out  1  downstream descriptor valid, held until i_descriptor_ack.
- ov_descriptor  out  DES_W  forwarded descriptor.
- ov_descriptor_src  out  PW  source port of the forwarded descriptor.
- i_descriptor_ack  in  1  downstream acceptance, single-cycle pulse.
- o_timeout_err  out  1  one-cycle pulse when a descriptor is dropped on timeout.
- ov_drop_cnt  out  16  count of timeout drops; saturates at 16'hFFFF.
- ov_arb_state  out  2  current FSM state, for debug.

Behaviour:
- Reset (reset_n low at an edge): all outputs 0, state IDLE_S, last_grant = PORT_NUM-1, timer 0. Reset mid-transfer discards the held descriptor; no ack is issued.
- States: IDLE_S=2'b00, WAIT_ACK_S=2'b01, GAP_S=2'b10; 2'b11 returns to IDLE_S with outputs cleared.
- IDLE_S, round-robin search:
  - Search ports last_grant+1, +2, … modulo PORT_NUM for the first with iv_descriptor_wr set.
  - If found (g), at the same edge: ov_descriptor <= port g descriptor, ov_descriptor_src <= g, o_descriptor_wr <= 1, ov_descriptor_ack[g] <= 1, last_grant <= g, timer <= 0, go to WAIT_ACK_S.
  - Latency from sampled request to o_descriptor_wr: 1 cycle.
  - If none: stay in IDLE_S, outputs 0.
- WAIT_ACK_S:
  - ov_descriptor_ack <= 0 (the ack is exactly one cycle wide).
  - o_descriptor_wr, ov_descriptor and ov_descriptor_src hold stable.
  - If i_descriptor_ack=1: clear wr, descriptor and src to 0, go to GAP_S.
  - Else if timer == ACK_TIMEOUT-1: clear wr, descriptor and src; pulse o_timeout_err; increment ov_drop_cnt (saturating); go to GAP_S.
  - Else timer <= timer+1.
  - If ack and timeout coincide, ack wins: no error, no count.
- GAP_S: one cycle, all pulses 0, back to IDLE_S. This guarantees a sender that was acked has dropped its wr before requests are sampled again, so no double grant.
- New requests arriving during WAIT_ACK_S or GAP_S are not granted; they remain pending, since senders hold wr.
- Back-to-back throughput with an immediate downstream ack: one descriptor every 3 cycles.
- i_descriptor_ack seen in IDLE_S or GAP_S is ignored.
- Fairness: a continuously requesting port waits at most PORT_NUM-1 grants.
- The upstream descriptor is passed through unmodified; bits [8:0] (bufid) are untouched.

Test Plan:
- Reset, then port 2 only requests with descriptor 46'h1_2345_6789_AB and ack 2 cycles later -> one cycle after the request: o_descriptor_wr=1, ov_descriptor=46'h1_2345_6789_AB, src=2, ov_descriptor_ack=4'b0100 for exactly 1 cycle; wr drops the cycle after ack; state 00→01→10→00.
- All 4 ports request continuously, downstream acks 1 cycle after wr -> grant order 0,1,2,3,0,…; one grant every 3 cycles; no port acked twice in a row.
- Ports 1 and 3 request after last_grant=1 -> port 3 granted first, then port 1.
- No downstream ack, ACK_TIMEOUT=255 -> o_descriptor_wr high for 255 cycles, o_timeout_err pulses once, ov_drop_cnt=1, return to IDLE_S.
- Ack and timeout in the same cycle -> no o_timeout_err, ov_drop_cnt unchanged.
- reset_n low during WAIT_ACK_S -> next cycle all outputs 0, state 00, last_grant=PORT_NUM-1; a subsequent request from port 0 is granted first.
